// File: rtl/data_mem_responder.sv
// Wait-stated word-addressed data memory that answers one load/store request at a time.
// Misaligned or out-of-range requests return err=1 and leave the array untouched.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int         ADDR_BITS = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   ready_q, ready_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;

  logic [31:0]            mem [DEPTH_WORDS];
  logic                   txn_we_s;
  logic [31:0]            txn_addr_s;
  logic [31:0]            txn_wdata_s;
  logic [ADDR_BITS-1:0]   idx_s;
  logic                   acc_err_s;
  logic                   resp_s;
  logic                   mem_we_s;

  function automatic logic access_error(input logic [31:0] a);
    logic misaligned;
    logic out_of_range;
    misaligned   = (a[1:0] != 2'b00);
    out_of_range = ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    return misaligned | out_of_range;
  endfunction

  // With no wait states the response is formed on the acceptance edge, so use the live inputs.
  always_comb begin
    txn_we_s    = we_q;
    txn_addr_s  = addr_q;
    txn_wdata_s = wdata_q;
    if (state_q == S_IDLE) begin
      txn_we_s    = we;
      txn_addr_s  = addr;
      txn_wdata_s = wdata;
    end else begin
      txn_we_s    = we_q;
      txn_addr_s  = addr_q;
      txn_wdata_s = wdata_q;
    end
  end

  assign idx_s     = txn_addr_s[ADDR_BITS+1:2];
  assign acc_err_s = access_error(txn_addr_s);

  // Next-state, capture and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response data, error flag and memory write strobe, all resolved on the edge entering RESP.
  always_comb begin
    resp_s   = (state_d == S_RESP);
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_s = 1'b0;
    if (resp_s) begin
      if (acc_err_s) begin
        rdata_d = 32'h0000_0000;
        err_d   = 1'b1;
      end else if (txn_we_s) begin
        mem_we_s = 1'b1;
        err_d    = 1'b0;
      end else begin
        rdata_d = mem[idx_s];
        err_d   = 1'b0;
      end
    end else begin
      rdata_d = rdata_q;
      err_d   = err_q;
    end
    ready_d = (state_d == S_RESP);
    busy_d  = (state_d != S_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[idx_s] <= txn_wdata_s;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: DUT 0 has two wait states, DUT 1 has none; a transaction-level
// model predicts every output on every cycle and directed tests pin the model with literals.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int WS0   = 2;
  localparam int WS1   = 0;

  logic        clk;
  logic        rst_n;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic        ready_o [2];
  logic [31:0] rdata_o [2];
  logic        err_o   [2];
  logic        busy_o  [2];

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
    .ready(ready_o[0]), .rdata(rdata_o[0]), .err(err_o[0]), .busy(busy_o[0]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
    .ready(ready_o[1]), .rdata(rdata_o[1]), .err(err_o[1]), .busy(busy_o[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          ws_of    [2];
  bit          m_busy   [2];
  bit          m_ready  [2];
  bit          m_err    [2];
  bit          m_known  [2];
  logic [31:0] m_rdata  [2];
  int          m_age    [2];
  bit          t_we     [2];
  logic [31:0] t_addr   [2];
  logic [31:0] t_wdata  [2];
  logic [31:0] m_mem    [int];

  function automatic void respond(input int k);
    longint unsigned word;
    word = longint'(t_addr[k]) / 4;
    m_ready[k] = 1'b1;
    if ((t_addr[k] % 4 != 0) || (word >= DEPTH)) begin
      m_err[k]   = 1'b1;
      m_rdata[k] = 32'h0;
      m_known[k] = 1'b1;
    end else if (t_we[k]) begin
      m_err[k] = 1'b0;
      m_mem[k * 1000 + int'(word)] = t_wdata[k];
    end else begin
      m_err[k] = 1'b0;
      if (m_mem.exists(k * 1000 + int'(word))) begin
        m_rdata[k] = m_mem[k * 1000 + int'(word)];
        m_known[k] = 1'b1;
      end else begin
        m_known[k] = 1'b0;
      end
    end
  endfunction

  initial begin
    ws_of[0] = WS0;
    ws_of[1] = WS1;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_ready[k] = 1'b0; m_err[k] = 1'b0; m_known[k] = 1'b1;
      m_rdata[k] = 32'h0; m_age[k] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          m_busy[k] = 1'b0; m_ready[k] = 1'b0; m_err[k] = 1'b0; m_known[k] = 1'b1;
          m_rdata[k] = 32'h0; m_age[k] = 0;
        end else if (m_busy[k] && m_ready[k]) begin
          m_busy[k]  = 1'b0;
          m_ready[k] = 1'b0;
        end else if (m_busy[k]) begin
          m_age[k]++;
          if (m_age[k] == ws_of[k]) respond(k);
        end else if (req_s[k]) begin
          t_we[k] = we_s[k]; t_addr[k] = addr_s[k]; t_wdata[k] = wdata_s[k];
          m_busy[k] = 1'b1;
          m_age[k]  = 0;
          if (ws_of[k] == 0) respond(k);
        end
      end
    end
  end

  // Compare every output of both DUTs against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("ready%0d", k), 32'(ready_o[k]), 32'(m_ready[k]));
          check($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(m_busy[k]));
          check($sformatf("err%0d", k), 32'(err_o[k]), 32'(m_err[k]));
          if (m_known[k]) check($sformatf("rdata%0d", k), rdata_o[k], m_rdata[k]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat);
    bit got;
    @(negedge clk);
    req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ready_o[k] === 1'b1) got = 1'b1;
    end
    rd = rdata_o[k];
    e  = err_o[k];
    req_s[k] = 1'b0;
    if (!got) check("ready_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  int          pulses[$];
  int          cyc;
  int          seen;

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = 32'h0; wdata_s[k] = 32'h0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    check("rst_ready", 32'(ready_o[0]), 32'd0);
    check("rst_busy", 32'(busy_o[0]), 32'd0);
    check("rst_rdata", rdata_o[0], 32'h0);
    check("rst_err", 32'(err_o[0]), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Store then load with two wait states.
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, e, lat);
    check("st_latency", 32'(lat), 32'd3);
    check("st_err", 32'(e), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, rd, e, lat);
    check("ld_latency", 32'(lat), 32'd3);
    check("ld_rdata", rd, 32'hDEAD_BEEF);
    check("ld_err", 32'(e), 32'd0);

    // Misaligned and out-of-range accesses; 0x100 would alias index 0 without the range check.
    txn(0, 1'b1, 32'h0, 32'hA5A5_0000, rd, e, lat);
    txn(0, 1'b0, 32'h13, 32'h0, rd, e, lat);
    check("mis_err", 32'(e), 32'd1);
    check("mis_rdata", rd, 32'h0);
    txn(0, 1'b1, 32'h100, 32'hFFFF_FFFF, rd, e, lat);
    check("oor_err", 32'(e), 32'd1);
    check("oor_rdata", rd, 32'h0);
    txn(0, 1'b0, 32'h0, 32'h0, rd, e, lat);
    check("idx0_kept", rd, 32'hA5A5_0000);
    check("idx0_err", 32'(e), 32'd0);

    // Zero wait states, req held high across a store and a load.
    @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h4; wdata_s[1] = 32'h1;
    seen = 0;
    for (cyc = 1; cyc <= 12 && seen < 2; cyc++) begin
      @(negedge clk);
      if (ready_o[1] === 1'b1) begin
        pulses.push_back(cyc);
        seen++;
        if (seen == 1) begin
          we_s[1] = 1'b0; wdata_s[1] = 32'h0;
        end else begin
          rd = rdata_o[1];
          req_s[1] = 1'b0;
        end
      end
    end
    check("b2b_pulses", 32'(seen), 32'd2);
    if (seen == 2) begin
      check("b2b_first", 32'(pulses[0]), 32'd1);
      check("b2b_period", 32'(pulses[1] - pulses[0]), 32'd2);
      check("b2b_rdata", rd, 32'h0000_0001);
    end

    // Reset during the second wait cycle of a store aborts it.
    txn(0, 1'b1, 32'h8, 32'h1234_5678, rd, e, lat);
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h8; wdata_s[0] = 32'hCAFE_0000;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    req_s[0] = 1'b0;
    #1;
    check("abort_busy", 32'(busy_o[0]), 32'd0);
    check("abort_ready", 32'(ready_o[0]), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready_o[0] === 1'b1) seen++;
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    txn(0, 1'b0, 32'h8, 32'h0, rd, e, lat);
    check("abort_rdata", rd, 32'h1234_5678);
    check("abort_err", 32'(e), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
